// File: rtl/iobuf_bus_sequencer.sv
// Half-duplex tri-state bus direction controller: sequences write beats and
// read samples with a guaranteed hi-Z turnaround gap on every direction change.
module iobuf_bus_sequencer #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1,
  parameter int RD_LATENCY  = 2
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             CMD_VALID,
  input  logic             CMD_WR,
  input  logic [WIDTH-1:0] CMD_DATA,
  output logic             CMD_READY,
  output logic [WIDTH-1:0] PAD_I,
  output logic [WIDTH-1:0] PAD_T,
  input  logic [WIDTH-1:0] PAD_O,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RD_VALID
);

  typedef enum logic [1:0] {S_TURN, S_IDLE, S_DRIVE, S_RD_WAIT} state_t;

  // Counters count down to zero; loading N-1 gives a dwell of exactly N cycles.
  localparam logic [3:0] TURN_LD = 4'(TURN_CYCLES - 1);
  localparam logic [3:0] RD_LD   = 4'(RD_LATENCY - 1);

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             pend, pend_nxt;
  logic [WIDTH-1:0] pad_i_nxt;
  logic             sample;
  logic             accept;

  assign CMD_READY = (state == S_IDLE) || (state == S_DRIVE);
  assign accept    = CMD_VALID && CMD_READY;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == '0) ? cnt : cnt - 4'd1;
    pend_nxt  = pend;
    pad_i_nxt = PAD_I;
    sample    = 1'b0;
    case (state)
      S_TURN: begin
        if (cnt == '0) begin
          if (pend) begin
            state_nxt = S_RD_WAIT;
            cnt_nxt   = RD_LD;
            pend_nxt  = 1'b0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        // IDLE is only reached through TURN, so a read may start immediately.
        if (accept) begin
          if (CMD_WR) begin
            state_nxt = S_DRIVE;
            pad_i_nxt = CMD_DATA;
          end else begin
            state_nxt = S_RD_WAIT;
            cnt_nxt   = RD_LD;
          end
        end
      end
      S_DRIVE: begin
        if (accept && CMD_WR) begin
          pad_i_nxt = CMD_DATA;
        end else begin
          state_nxt = S_TURN;
          cnt_nxt   = TURN_LD;
          pend_nxt  = accept;
        end
      end
      S_RD_WAIT: begin
        // Far end drove last, so the bus must turn around before anything else.
        if (cnt == '0) begin
          sample    = 1'b1;
          state_nxt = S_TURN;
          cnt_nxt   = TURN_LD;
        end
      end
      default: begin
        state_nxt = S_TURN;
        cnt_nxt   = TURN_LD;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= S_TURN;
      cnt      <= TURN_LD;
      pend     <= 1'b0;
      PAD_I    <= '0;
      PAD_T    <= '1;
      RD_DATA  <= '0;
      RD_VALID <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pend     <= pend_nxt;
      PAD_I    <= pad_i_nxt;
      PAD_T    <= {WIDTH{state_nxt != S_DRIVE}};
      RD_VALID <= sample;
      if (sample) RD_DATA <= PAD_O;
    end
  end

endmodule

// File: tb/tb_iobuf_bus_sequencer.sv
// Bench for iobuf_bus_sequencer: directed scenarios plus randomized traffic
// against a timestamp-based model of bus ownership, on three parameter sets.
module tb_iobuf_bus_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr;
  logic       cmd_valid, cmd_wr;
  logic [7:0] cmd_data, pad_o;
  logic [2:0] rdy_a, vld_a;
  logic [2:0][7:0] pad_i_a, pad_t_a, rd_data_a;

  iobuf_bus_sequencer #(.WIDTH(8), .TURN_CYCLES(1), .RD_LATENCY(2)) u_dut0 (
    .CLK(clk), .CLR(clr), .CMD_VALID(cmd_valid), .CMD_WR(cmd_wr), .CMD_DATA(cmd_data),
    .CMD_READY(rdy_a[0]), .PAD_I(pad_i_a[0]), .PAD_T(pad_t_a[0]), .PAD_O(pad_o),
    .RD_DATA(rd_data_a[0]), .RD_VALID(vld_a[0]));
  iobuf_bus_sequencer #(.WIDTH(8), .TURN_CYCLES(1), .RD_LATENCY(3)) u_dut1 (
    .CLK(clk), .CLR(clr), .CMD_VALID(cmd_valid), .CMD_WR(cmd_wr), .CMD_DATA(cmd_data),
    .CMD_READY(rdy_a[1]), .PAD_I(pad_i_a[1]), .PAD_T(pad_t_a[1]), .PAD_O(pad_o),
    .RD_DATA(rd_data_a[1]), .RD_VALID(vld_a[1]));
  iobuf_bus_sequencer #(.WIDTH(8), .TURN_CYCLES(2), .RD_LATENCY(2)) u_dut2 (
    .CLK(clk), .CLR(clr), .CMD_VALID(cmd_valid), .CMD_WR(cmd_wr), .CMD_DATA(cmd_data),
    .CMD_READY(rdy_a[2]), .PAD_I(pad_i_a[2]), .PAD_T(pad_t_a[2]), .PAD_O(pad_o),
    .RD_DATA(rd_data_a[2]), .RD_VALID(vld_a[2]));

  int sel = 0;
  int T = 1, L = 2;
  logic       o_rdy, o_vld;
  logic [7:0] o_pad_i, o_pad_t, o_rd_data;

  always_comb begin
    o_rdy     = rdy_a[sel];
    o_vld     = vld_a[sel];
    o_pad_i   = pad_i_a[sel];
    o_pad_t   = pad_t_a[sel];
    o_rd_data = rd_data_a[sel];
  end

  int checks = 0, failures = 0, cyc = 0;
  localparam int INF = 1 << 30;

  // Model: who owns the bus is tracked as cycle timestamps, not states.
  int drv_cyc, free_at, samp_cyc, vld_cyc;
  logic [7:0] m_pad_i, m_rd_data;

  function automatic logic m_rdy(int c);
    return (c == drv_cyc) || (c >= free_at);
  endfunction

  function automatic logic [7:0] m_pad_t(int c);
    return (c == drv_cyc) ? 8'h00 : 8'hFF;
  endfunction

  task automatic model_reset();
    drv_cyc = -1; free_at = cyc + T; samp_cyc = -1; vld_cyc = -1;
    m_pad_i = 8'h00; m_rd_data = 8'h00;
  endtask

  task automatic model_edge(input logic v, input logic w, input logic [7:0] d, input logic [7:0] po);
    int s;
    logic rdy, drv;
    rdy = m_rdy(cyc);
    drv = (cyc == drv_cyc);
    if (cyc == samp_cyc) m_rd_data = po;
    if (v && rdy) begin
      if (w) begin
        drv_cyc = cyc + 1; free_at = INF; m_pad_i = d;
      end else begin
        s = cyc + (drv ? T : 0) + L;
        samp_cyc = s; vld_cyc = s + 1; free_at = s + T + 1;
      end
    end else if (drv) begin
      free_at = cyc + T + 1;
    end
  endtask

  // Drive one cycle of inputs, advance the model and the clock, return past the negedge.
  task automatic tick(input logic v, input logic w, input logic [7:0] d, input logic [7:0] po);
    cmd_valid = v; cmd_wr = w; cmd_data = d; pad_o = po;
    if (!clr) model_edge(v, w, d, po);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic apply_reset(input int s);
    sel = s;
    T = (s == 2) ? 2 : 1;
    L = (s == 1) ? 3 : 2;
    clr = 1'b1;
    tick(1'b0, 1'b0, 8'h00, 8'h00);
    tick(1'b0, 1'b0, 8'h00, 8'h00);
    clr = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset(2);
    wait_cycles(2);
    checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL rst_idle_rdy got=%b exp=1", o_rdy); end
    tick(1'b1, 1'b1, 8'h3C, 8'h00);
    checks++; if (o_pad_t !== 8'h00) begin failures++; $display("FAIL rst_drive pad_t got=%h exp=00", o_pad_t); end
    clr = 1'b1;
    #1;
    checks++; if (o_pad_t !== 8'hFF) begin failures++; $display("FAIL rst_async pad_t got=%h exp=ff", o_pad_t); end
    checks++; if (o_pad_i !== 8'h00) begin failures++; $display("FAIL rst_async pad_i got=%h exp=00", o_pad_i); end
    checks++; if (o_rdy !== 1'b0) begin failures++; $display("FAIL rst_async rdy got=%b exp=0", o_rdy); end
    tick(1'b0, 1'b0, 8'h00, 8'h00);
    tick(1'b0, 1'b0, 8'h00, 8'h00);
    clr = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++; if (o_pad_t !== 8'hFF) begin failures++; $display("FAIL rst_turn%0d pad_t got=%h exp=ff", k, o_pad_t); end
      checks++; if (o_rdy !== 1'b0) begin failures++; $display("FAIL rst_turn%0d rdy got=%b exp=0", k, o_rdy); end
      checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL rst_turn%0d vld got=%b exp=0", k, o_vld); end
      wait_cycles(1);
    end
    checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL rst_release rdy got=%b exp=1", o_rdy); end
  endtask

  task automatic test_burst_write();
    logic [7:0] beats [3];
    beats = '{8'h11, 8'h22, 8'h33};
    apply_reset(0);
    wait_cycles(1);
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b1, beats[k], 8'h00);
      checks++; if (o_pad_t !== 8'h00) begin failures++; $display("FAIL burst%0d pad_t got=%h exp=00", k, o_pad_t); end
      checks++; if (o_pad_i !== beats[k]) begin failures++; $display("FAIL burst%0d pad_i got=%h exp=%h", k, o_pad_i, beats[k]); end
    end
    tick(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (o_pad_t !== 8'hFF) begin failures++; $display("FAIL burst_turn pad_t got=%h exp=ff", o_pad_t); end
    checks++; if (o_rdy !== 1'b0) begin failures++; $display("FAIL burst_turn rdy got=%b exp=0", o_rdy); end
    checks++; if (o_pad_i !== 8'h33) begin failures++; $display("FAIL burst_hold pad_i got=%h exp=33", o_pad_i); end
    tick(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL burst_ready rdy got=%b exp=1", o_rdy); end
  endtask

  task automatic test_read_idle();
    apply_reset(1);
    wait_cycles(1);
    tick(1'b1, 1'b0, 8'h00, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      checks++; if (o_pad_t !== 8'hFF || o_rdy !== 1'b0 || o_vld !== 1'b0) begin
        failures++; $display("FAIL rd_wait%0d t/rdy/vld got=%h/%b/%b exp=ff/0/0", k, o_pad_t, o_rdy, o_vld);
      end
      tick(1'b0, 1'b0, 8'h00, (k == 3) ? 8'hA5 : 8'h00);
    end
    checks++; if (o_vld !== 1'b1 || o_rd_data !== 8'hA5) begin
      failures++; $display("FAIL rd_idle vld/data got=%b/%h exp=1/a5", o_vld, o_rd_data);
    end
    checks++; if (o_pad_t !== 8'hFF) begin failures++; $display("FAIL rd_idle pad_t got=%h exp=ff", o_pad_t); end
    tick(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (o_vld !== 1'b0 || o_rd_data !== 8'hA5) begin
      failures++; $display("FAIL rd_idle_after vld/data got=%b/%h exp=0/a5", o_vld, o_rd_data);
    end
    checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL rd_idle_ready rdy got=%b exp=1", o_rdy); end
  endtask

  task automatic test_write_then_read();
    apply_reset(2);
    wait_cycles(2);
    tick(1'b1, 1'b1, 8'h5A, 8'h00);
    checks++; if (o_pad_t !== 8'h00 || o_pad_i !== 8'h5A) begin
      failures++; $display("FAIL wr_rd_beat t/i got=%h/%h exp=00/5a", o_pad_t, o_pad_i);
    end
    tick(1'b1, 1'b0, 8'h00, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      checks++; if (o_pad_t !== 8'hFF || o_vld !== 1'b0 || o_rdy !== 1'b0) begin
        failures++; $display("FAIL wr_rd_gap%0d t/vld/rdy got=%h/%b/%b exp=ff/0/0", k, o_pad_t, o_vld, o_rdy);
      end
      tick(1'b0, 1'b0, 8'h00, (k == 4) ? 8'hC3 : 8'h3C);
    end
    checks++; if (o_vld !== 1'b1 || o_rd_data !== 8'hC3) begin
      failures++; $display("FAIL wr_rd_result vld/data got=%b/%h exp=1/c3", o_vld, o_rd_data);
    end
  endtask

  task automatic test_read_then_write();
    apply_reset(0);
    wait_cycles(1);
    tick(1'b1, 1'b0, 8'h00, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      checks++; if (o_rdy !== 1'b0 || o_pad_t !== 8'hFF) begin
        failures++; $display("FAIL rd_wr_block%0d rdy/t got=%b/%h exp=0/ff", k, o_rdy, o_pad_t);
      end
      tick(1'b1, 1'b1, 8'h77, 8'h96);
    end
    checks++; if (o_rdy !== 1'b1 || o_pad_t !== 8'hFF) begin
      failures++; $display("FAIL rd_wr_idle rdy/t got=%b/%h exp=1/ff", o_rdy, o_pad_t);
    end
    checks++; if (o_rd_data !== 8'h96) begin failures++; $display("FAIL rd_wr_data got=%h exp=96", o_rd_data); end
    tick(1'b1, 1'b1, 8'h77, 8'h00);
    checks++; if (o_pad_t !== 8'h00 || o_pad_i !== 8'h77) begin
      failures++; $display("FAIL rd_wr_drive t/i got=%h/%h exp=00/77", o_pad_t, o_pad_i);
    end
    wait_cycles(2);
  endtask

  task automatic test_reset_rd_wait();
    apply_reset(1);
    wait_cycles(1);
    tick(1'b1, 1'b0, 8'h00, 8'h5A);
    tick(1'b0, 1'b0, 8'h00, 8'h5A);
    clr = 1'b1;
    #1;
    checks++; if (o_vld !== 1'b0 || o_rd_data !== 8'h00) begin
      failures++; $display("FAIL rstrd_async vld/data got=%b/%h exp=0/00", o_vld, o_rd_data);
    end
    tick(1'b0, 1'b0, 8'h00, 8'h5A);
    tick(1'b0, 1'b0, 8'h00, 8'h5A);
    clr = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      checks++; if (o_vld !== 1'b0 || o_rd_data !== 8'h00) begin
        failures++; $display("FAIL rstrd_after%0d vld/data got=%b/%h exp=0/00", k, o_vld, o_rd_data);
      end
      tick(1'b0, 1'b0, 8'h00, 8'h5A);
    end
  endtask

  task automatic test_random(input int s, input int n);
    apply_reset(s);
    for (int i = 0; i < n; i++) begin
      checks++; if (o_rdy !== m_rdy(cyc)) begin
        failures++; $display("FAIL rand%0d c%0d rdy got=%b exp=%b", s, cyc, o_rdy, m_rdy(cyc));
      end
      checks++; if (o_pad_t !== m_pad_t(cyc)) begin
        failures++; $display("FAIL rand%0d c%0d pad_t got=%h exp=%h", s, cyc, o_pad_t, m_pad_t(cyc));
      end
      checks++; if (o_pad_i !== m_pad_i) begin
        failures++; $display("FAIL rand%0d c%0d pad_i got=%h exp=%h", s, cyc, o_pad_i, m_pad_i);
      end
      checks++; if (o_vld !== (cyc == vld_cyc)) begin
        failures++; $display("FAIL rand%0d c%0d vld got=%b exp=%b", s, cyc, o_vld, cyc == vld_cyc);
      end
      checks++; if (o_rd_data !== m_rd_data) begin
        failures++; $display("FAIL rand%0d c%0d rd_data got=%h exp=%h", s, cyc, o_rd_data, m_rd_data);
      end
      if ($urandom_range(0, 149) == 0) begin
        clr = 1'b1;
        #1;
        checks++; if (o_pad_t !== 8'hFF || o_rdy !== 1'b0 || o_vld !== 1'b0) begin
          failures++; $display("FAIL rand%0d c%0d async_rst t/rdy/vld got=%h/%b/%b exp=ff/0/0", s, cyc, o_pad_t, o_rdy, o_vld);
        end
        tick(1'b0, 1'b0, 8'h00, 8'h00);
        tick(1'b0, 1'b0, 8'h00, 8'h00);
        clr = 1'b0;
        model_reset();
      end else begin
        tick($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      end
    end
  endtask

  initial begin
    clr = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_data = 8'h00; pad_o = 8'h00;
    model_reset();
    test_reset();
    test_burst_write();
    test_read_idle();
    test_write_then_read();
    test_read_then_write();
    test_reset_rd_wait();
    test_random(0, 600);
    test_random(1, 600);
    test_random(2, 600);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iobuf_bus_sequencer.md
# iobuf_bus_sequencer

Clocked direction controller for a half-duplex bidirectional data bus built from WIDTH single-bit tri-state I/O buffers. It accepts write/read commands on a ready/valid command port and drives the buffers' data input (PAD_I) and active-low tri-state enable (PAD_T). It also samples the buffers' pad-side output (PAD_O) for reads. A guaranteed hi-Z turnaround gap is inserted on every bus direction change, so neither end can drive the pad at the same time.

## Interface
- WIDTH, 8, bus width; one tri-state buffer per bit.
- TURN_CYCLES, 1, hi-Z turnaround cycles on every direction change; legal range 1..15.
- RD_LATENCY, 2, hi-Z wait cycles between the start of a read and the sample of PAD_O; legal range 1..15.

- CLK  input  1  clock; all state changes on rising edge.
- CLR  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  command present.
- CMD_WR  input  1  1 = write, 0 = read; qualified by CMD_VALID.
- CMD_DATA  input  WIDTH  write data; ignored for reads.
- CMD_READY  output  1  command accepted when CMD_VALID & CMD_READY at a rising edge.
- PAD_I  output  WIDTH  data to the buffer I inputs.
- PAD_T  output  WIDTH  tri-state controls; 1 = hi-Z, 0 = drive; all bits always equal.
- PAD_O  input  WIDTH  pad value from the buffer O outputs.
- RD_DATA  output  WIDTH  captured read data; holds until the next capture.
- RD_VALID  output  1  one-cycle pulse when RD_DATA is updated.

## Operation
- All outputs are registered; CMD_READY is decoded from the state register only.
- States:
  - TURN: hi-Z; counts TURN_CYCLES.
  - IDLE: hi-Z; the bus is known free.
  - DRIVE: PAD_T = 0.
  - RD_WAIT: hi-Z; counts RD_LATENCY.
- CMD_READY is 1 in IDLE and DRIVE, and 0 in TURN and RD_WAIT.
- IDLE + write accepted -> DRIVE next cycle; PAD_I = CMD_DATA, PAD_T = 0.
- IDLE + read accepted -> RD_WAIT. No turnaround is needed, because IDLE is always entered through TURN.
- DRIVE, by input in that cycle:
  - Write accepted -> stay in DRIVE; PAD_I updates to the new data next cycle, so back-to-back writes are one beat per cycle.
  - Read accepted -> TURN with a pending-read flag set.
  - No command -> TURN with no pending read.
- Each write beat is on the pad for exactly one cycle. PAD_I keeps its last value while PAD_T = 1.
- TURN, when its count completes: pending read -> RD_WAIT (flag cleared); otherwise -> IDLE.
- RD_WAIT, when its count completes: PAD_O is registered into RD_DATA, RD_VALID pulses next cycle, and the state goes to TURN. The far end drove last, so a turnaround is always required.
- Counters reload on every state entry. TURN always lasts exactly TURN_CYCLES cycles, RD_WAIT exactly RD_LATENCY cycles.
- CLR asserted (asynchronous, effective immediately, any state):
  - PAD_T = all ones, PAD_I = 0, RD_DATA = 0, RD_VALID = 0, CMD_READY = 0.
  - Pending read is dropped; state = TURN with the counter loaded.
  - No RD_VALID is ever produced for a read interrupted by reset.
- After CLR deasserts, the block spends TURN_CYCLES cycles in TURN, then goes to IDLE.

## Timing
- Reset values: PAD_T = {WIDTH{1}}, PAD_I = 0, RD_DATA = 0, RD_VALID = 0, CMD_READY = 0.
- Write accepted in IDLE at edge N -> PAD_T = 0 and PAD_I = data during cycle N+1.
- Last write beat in cycle M with no new command -> PAD_T = 1 from cycle M+1 through M+TURN_CYCLES; CMD_READY = 1 again in cycle M+TURN_CYCLES+1.
- Read accepted in IDLE at edge N:
  - RD_WAIT during cycles N+1 .. N+RD_LATENCY.
  - PAD_O is sampled at the edge ending cycle N+RD_LATENCY.
  - RD_VALID = 1 in cycle N+RD_LATENCY+1, which is also the first TURN cycle.
  - IDLE is reached at cycle N+RD_LATENCY+TURN_CYCLES+1.
- Read accepted in DRIVE at edge N: TURN_CYCLES cycles of TURN, then RD_LATENCY cycles of RD_WAIT, then the sample. RD_VALID arrives in cycle N+TURN_CYCLES+RD_LATENCY+1.
- PAD_T is never 0 in any cycle within TURN_CYCLES cycles of a cycle in which the far end may drive (RD_WAIT).
- No combinational path from any input to any output.

## Test plan
- Reset: assert CLR mid-DRIVE with WIDTH=8 -> PAD_T = 0xFF immediately, and 0xFF holds for TURN_CYCLES cycles after release; CMD_READY = 0 until then; RD_VALID stays 0.
- Burst write, default params: writes 0x11, 0x22, 0x33 on consecutive edges, then idle -> PAD_I = 0x11/0x22/0x33 in three consecutive cycles with PAD_T = 0x00; then PAD_T = 0xFF for 1 cycle; CMD_READY = 1 in the following cycle.
- Read from IDLE, RD_LATENCY=3, far end drives PAD_O = 0xA5 only in the sample cycle -> RD_DATA = 0xA5 with a single-cycle RD_VALID 4 cycles after accept; PAD_T = 0xFF throughout.
- Write then read, TURN_CYCLES=2, RD_LATENCY=2: write 0x5A, then read accepted in DRIVE -> exactly 2 hi-Z TURN cycles, then 2 RD_WAIT cycles; RD_VALID at accept+5; no cycle with PAD_T = 0 after the write beat.
- Read then write: write offered the cycle after the read is accepted -> CMD_READY stays low through RD_WAIT and TURN; the write drives first at read-accept + RD_LATENCY + TURN_CYCLES + 2.
- Reset during RD_WAIT: assert CLR one cycle before the sample -> no RD_VALID pulse, and RD_DATA reads 0.
